chip8_call_ctrl: RTL and testbench

Sequencer for the Chip-8 CALL (2NNN) and RET (00EE) instructions. It sits between the CPU instruction decoder and the 16-entry call stack. It converts a one-cycle decoder request into the stack's two-cycle push/pop write-enable protocol and tracks stack depth. It returns the next program counter to the fetch stage with a one-cycle done pulse.

---
 rtl/chip8_call_ctrl.sv | 142 ++++++++++++++
 tb/tb_chip8_call_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_call_ctrl.sv
// chip8_call_ctrl: sequencer for the Chip-8 CALL (2NNN) and RET (00EE)
// instructions. Converts a one-cycle decoder request into the stack's
// two-cycle push/pop write-enable protocol, tracks stack depth and returns
// the next program counter with a one-cycle done pulse.
//
// Optional feature macro: CHIP8_STACK_FAULT_EN
//   defined   -> CALL at full depth or RET at empty depth goes to FAULT
//   undefined -> no checks, fault tied low, depth wraps modulo 2^5
module chip8_call_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic                     cpu_clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     op_ret,
  input  logic [11:0]              target,
  input  logic [15:0]              pc,
  output logic [1:0]               stack_we,
  output logic [15:0]              stack_writedata,
  input  logic [15:0]              stack_outdata,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              new_pc,
  output logic                     fault,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int DW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_A,
    PUSH_B,
    POP_A,
    POP_B,
    POP_WAIT,
    DONE
`ifdef CHIP8_STACK_FAULT_EN
    ,
    FAULT
`endif
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  we_next;
  logic [11:0] target_q;

`ifdef CHIP8_STACK_FAULT_EN
  logic overflow;
  logic underflow;

  assign overflow  = (depth == DW'(DEPTH));
  assign underflow = (depth == '0);
`endif

  // Next-state selection plus the stack write-enable the next state will drive
  always_comb begin
    state_next = state;
    we_next    = 2'd0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op_ret) begin
`ifdef CHIP8_STACK_FAULT_EN
            state_next = underflow ? FAULT : POP_A;
`else
            state_next = POP_A;
`endif
          end else begin
`ifdef CHIP8_STACK_FAULT_EN
            state_next = overflow ? FAULT : PUSH_A;
`else
            state_next = PUSH_A;
`endif
          end
        end
      end
      PUSH_A:   state_next = PUSH_B;
      PUSH_B:   state_next = DONE;
      POP_A:    state_next = POP_B;
      POP_B:    state_next = POP_WAIT;
      POP_WAIT: state_next = DONE;
      DONE:     state_next = IDLE;
`ifdef CHIP8_STACK_FAULT_EN
      FAULT:    state_next = IDLE;
`endif
      default:  state_next = IDLE;
    endcase

    case (state_next)
      PUSH_A, PUSH_B: we_next = 2'd1;
      POP_A, POP_B:   we_next = 2'd2;
      default:        we_next = 2'd0;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge cpu_clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered datapath: write-enable, pushed value, next PC and depth counter
  always_ff @(posedge cpu_clk) begin
    if (!reset_n) begin
      stack_we        <= 2'd0;
      stack_writedata <= 16'h0000;
      new_pc          <= 16'h0200;
      depth           <= '0;
      target_q        <= 12'h000;
    end else begin
      stack_we <= we_next;
      if (state == IDLE && state_next == PUSH_A) begin
        target_q        <= target;
        stack_writedata <= pc + 16'd2;
      end
      if (state == PUSH_B) begin
        depth  <= depth + DW'(1);
        new_pc <= {4'h0, target_q};
      end
      if (state == POP_A) begin
        depth <= depth - DW'(1);
      end
      if (state == POP_WAIT) begin
        new_pc <= stack_outdata & 16'h0FFF;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
`ifdef CHIP8_STACK_FAULT_EN
  assign fault = (state == FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_call_ctrl.sv
// tb_chip8_call_ctrl: directed self-checking bench for chip8_call_ctrl.
// Includes a small 16-entry stack model that honours the two-cycle
// push/pop write-enable protocol. Fault checks depend on CHIP8_STACK_FAULT_EN.
module tb_chip8_call_ctrl;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        op_ret  = 1'b0;
  logic [11:0] target  = 12'h000;
  logic [15:0] pc      = 16'h0000;
  logic [1:0]  stack_we;
  logic [15:0] stack_writedata;
  logic [15:0] stack_outdata;
  logic        busy;
  logic        done;
  logic [15:0] new_pc;
  logic        fault;
  logic [4:0]  depth;

  int errors = 0;
  int checks = 0;

  logic [15:0] ram [16];
  logic [3:0]  sp;
  logic [1:0]  we_prev;

  chip8_call_ctrl #(.DEPTH(16)) dut (
    .cpu_clk         (cpu_clk),
    .reset_n         (reset_n),
    .start           (start),
    .op_ret          (op_ret),
    .target          (target),
    .pc              (pc),
    .stack_we        (stack_we),
    .stack_writedata (stack_writedata),
    .stack_outdata   (stack_outdata),
    .busy            (busy),
    .done            (done),
    .new_pc          (new_pc),
    .fault           (fault),
    .depth           (depth)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Stack model: write on the first push cycle, bump pointer on the second;
  // decrement pointer on the first pop cycle so the entry is readable after
  always @(posedge cpu_clk) begin
    if (!reset_n) begin
      sp      <= 4'd0;
      we_prev <= 2'd0;
    end else begin
      we_prev <= stack_we;
      if (stack_we == 2'd1 && we_prev != 2'd1) ram[sp] <= stack_writedata;
      if (stack_we == 2'd1 && we_prev == 2'd1) sp <= sp + 4'd1;
      if (stack_we == 2'd2 && we_prev != 2'd2) sp <= sp - 4'd1;
    end
  end

  assign stack_outdata = ram[sp];

  // Global watchdog so the bench can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  // Issue one request and watch it to completion plus one cycle back in IDLE
  task automatic issue(input logic ret, input logic [15:0] p, input logic [11:0] t,
                       output int lat, output int ndone, output int nfault,
                       output int npush, output int npop, output logic [15:0] wd);
    op_ret = ret;
    pc     = p;
    target = t;
    start  = 1'b1;
    lat    = -1;
    ndone  = 0;
    nfault = 0;
    npush  = 0;
    npop   = 0;
    wd     = 16'h0000;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      start = 1'b0;
      if (stack_we == 2'd1) begin
        if (npush == 0) wd = stack_writedata;
        npush++;
      end
      if (stack_we == 2'd2) npop++;
      if (done) ndone++;
      if (fault) nfault++;
      if (lat >= 0 && i > lat) break;
      if ((done || fault) && lat < 0) lat = i;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (stack_we !== 2'd0) begin errors++; $display("[TB] FAIL reset_we: got %0d expected 0", stack_we); end
    checks++; if (depth !== 5'd0) begin errors++; $display("[TB] FAIL reset_depth: got %0d expected 0", depth); end
    checks++; if (new_pc !== 16'h0200) begin errors++; $display("[TB] FAIL reset_new_pc: got %h expected 0200", new_pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0 || fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_fault: got %b%b expected 00", done, fault); end
  endtask

  task automatic test_call();
    do_reset();
    op_ret = 1'b0; pc = 16'h0234; target = 12'h456; start = 1'b1;
    cyc();
    start = 1'b0;
    checks++; if (stack_we !== 2'd1 || stack_writedata !== 16'h0236 || busy !== 1'b1) begin errors++; $display("[TB] FAIL call_push_a: got we=%0d wd=%h busy=%b expected we=1 wd=0236 busy=1", stack_we, stack_writedata, busy); end
    cyc();
    checks++; if (stack_we !== 2'd1 || stack_writedata !== 16'h0236 || done !== 1'b0) begin errors++; $display("[TB] FAIL call_push_b: got we=%0d wd=%h done=%b expected we=1 wd=0236 done=0", stack_we, stack_writedata, done); end
    cyc();
    checks++; if (done !== 1'b1 || new_pc !== 16'h0456 || stack_we !== 2'd0) begin errors++; $display("[TB] FAIL call_done: got done=%b pc=%h we=%0d expected done=1 pc=0456 we=0", done, new_pc, stack_we); end
    checks++; if (depth !== 5'd1) begin errors++; $display("[TB] FAIL call_depth: got %0d expected 1", depth); end
    cyc();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || new_pc !== 16'h0456) begin errors++; $display("[TB] FAIL call_idle: got done=%b busy=%b pc=%h expected 0 0 0456", done, busy, new_pc); end
  endtask

  task automatic test_nested();
    int lat, nd, nf, npu, npo;
    logic [15:0] wd;
    do_reset();
    issue(1'b0, 16'h0200, 12'h300, lat, nd, nf, npu, npo, wd);
    checks++; if (new_pc !== 16'h0300 || depth !== 5'd1 || lat !== 3) begin errors++; $display("[TB] FAIL nest_call1: got pc=%h depth=%0d lat=%0d expected 0300 1 3", new_pc, depth, lat); end
    issue(1'b0, 16'h0302, 12'h400, lat, nd, nf, npu, npo, wd);
    checks++; if (new_pc !== 16'h0400 || depth !== 5'd2 || wd !== 16'h0304) begin errors++; $display("[TB] FAIL nest_call2: got pc=%h depth=%0d wd=%h expected 0400 2 0304", new_pc, depth, wd); end
    issue(1'b1, 16'h0400, 12'h000, lat, nd, nf, npu, npo, wd);
    checks++; if (new_pc !== 16'h0304 || depth !== 5'd1) begin errors++; $display("[TB] FAIL nest_ret1: got pc=%h depth=%0d expected 0304 1", new_pc, depth); end
    checks++; if (lat !== 4 || npo !== 2 || nd !== 1) begin errors++; $display("[TB] FAIL nest_ret1_timing: got lat=%0d pops=%0d dones=%0d expected 4 2 1", lat, npo, nd); end
    issue(1'b1, 16'h0304, 12'h000, lat, nd, nf, npu, npo, wd);
    checks++; if (new_pc !== 16'h0202 || depth !== 5'd0 || lat !== 4) begin errors++; $display("[TB] FAIL nest_ret2: got pc=%h depth=%0d lat=%0d expected 0202 0 4", new_pc, depth, lat); end
  endtask

  task automatic test_wrap_mask();
    int lat, nd, nf, npu, npo;
    logic [15:0] wd;
    do_reset();
    issue(1'b0, 16'hFFFE, 12'hABC, lat, nd, nf, npu, npo, wd);
    checks++; if (wd !== 16'h0000 || new_pc !== 16'h0ABC || npu !== 2) begin errors++; $display("[TB] FAIL pc_wrap: got wd=%h pc=%h pushes=%0d expected 0000 0ABC 2", wd, new_pc, npu); end
    issue(1'b0, 16'hF123, 12'h001, lat, nd, nf, npu, npo, wd);
    checks++; if (wd !== 16'hF125 || depth !== 5'd2) begin errors++; $display("[TB] FAIL high_push: got wd=%h depth=%0d expected F125 2", wd, depth); end
    issue(1'b1, 16'h0001, 12'h000, lat, nd, nf, npu, npo, wd);
    checks++; if (new_pc !== 16'h0125) begin errors++; $display("[TB] FAIL ret_mask: got %h expected 0125", new_pc); end
    issue(1'b1, 16'h0125, 12'h000, lat, nd, nf, npu, npo, wd);
    checks++; if (new_pc !== 16'h0000 || depth !== 5'd0) begin errors++; $display("[TB] FAIL ret_zero: got pc=%h depth=%0d expected 0000 0", new_pc, depth); end
  endtask

  task automatic test_busy_start();
    int npu, nd;
    do_reset();
    npu = 0;
    nd  = 0;
    op_ret = 1'b0; pc = 16'h0500; target = 12'h600; start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 1) op_ret = 1'b1;
      if (i >= 3) start = 1'b0;
      if (stack_we == 2'd1) npu++;
      if (done) nd++;
    end
    checks++; if (npu !== 2 || nd !== 1) begin errors++; $display("[TB] FAIL busy_ignore: got pushes=%0d dones=%0d expected 2 1", npu, nd); end
    checks++; if (depth !== 5'd1 || new_pc !== 16'h0600 || busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after: got depth=%0d pc=%h busy=%b expected 1 0600 0", depth, new_pc, busy); end
  endtask

  task automatic test_reset_mid();
    int lat, nd, nf, npu, npo;
    logic [15:0] wd;
    do_reset();
    op_ret = 1'b0; pc = 16'h0700; target = 12'h800; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    reset_n = 1'b0;
    cyc();
    checks++; if (busy !== 1'b0 || depth !== 5'd0 || done !== 1'b0 || stack_we !== 2'd0 || new_pc !== 16'h0200) begin errors++; $display("[TB] FAIL reset_mid: got busy=%b depth=%0d done=%b we=%0d pc=%h expected 0 0 0 0 0200", busy, depth, done, stack_we, new_pc); end
    reset_n = 1'b1;
    cyc();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_nodone: got done=%b busy=%b expected 0 0", done, busy); end
    issue(1'b0, 16'h0300, 12'h123, lat, nd, nf, npu, npo, wd);
    checks++; if (wd !== 16'h0302 || new_pc !== 16'h0123 || depth !== 5'd1 || lat !== 3) begin errors++; $display("[TB] FAIL reset_mid_call: got wd=%h pc=%h depth=%0d lat=%0d expected 0302 0123 1 3", wd, new_pc, depth, lat); end
  endtask

  task automatic test_overflow();
    int lat, nd, nf, npu, npo;
    logic [15:0] wd;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 16'h0200 + 16'(i * 2), 12'h100, lat, nd, nf, npu, npo, wd);
    end
    checks++; if (depth !== 5'd16) begin errors++; $display("[TB] FAIL full_depth: got %0d expected 16", depth); end
`ifdef CHIP8_STACK_FAULT_EN
    issue(1'b0, 16'h0400, 12'h200, lat, nd, nf, npu, npo, wd);
    checks++; if (nf !== 1 || nd !== 0 || npu !== 0 || depth !== 5'd16 || lat !== 1) begin errors++; $display("[TB] FAIL overflow: got faults=%0d dones=%0d pushes=%0d depth=%0d lat=%0d expected 1 0 0 16 1", nf, nd, npu, depth, lat); end
    checks++; if (new_pc !== 16'h0100) begin errors++; $display("[TB] FAIL overflow_pc: got %h expected 0100", new_pc); end
    issue(1'b1, 16'h0000, 12'h000, lat, nd, nf, npu, npo, wd);
    checks++; if (new_pc !== 16'h0220 || depth !== 5'd15) begin errors++; $display("[TB] FAIL first_ret: got pc=%h depth=%0d expected 0220 15", new_pc, depth); end
    for (int i = 0; i < 15; i++) begin
      issue(1'b1, 16'h0000, 12'h000, lat, nd, nf, npu, npo, wd);
    end
    checks++; if (new_pc !== 16'h0202 || depth !== 5'd0) begin errors++; $display("[TB] FAIL last_ret: got pc=%h depth=%0d expected 0202 0", new_pc, depth); end
    issue(1'b1, 16'h0000, 12'h000, lat, nd, nf, npu, npo, wd);
    checks++; if (nf !== 1 || nd !== 0 || npo !== 0 || depth !== 5'd0 || new_pc !== 16'h0202) begin errors++; $display("[TB] FAIL underflow: got faults=%0d dones=%0d pops=%0d depth=%0d pc=%h expected 1 0 0 0 0202", nf, nd, npo, depth, new_pc); end
`else
    issue(1'b0, 16'h0400, 12'h200, lat, nd, nf, npu, npo, wd);
    checks++; if (nf !== 0 || nd !== 1 || npu !== 2 || depth !== 5'd17) begin errors++; $display("[TB] FAIL overflow_wrap: got faults=%0d dones=%0d pushes=%0d depth=%0d expected 0 1 2 17", nf, nd, npu, depth); end
    issue(1'b1, 16'h0000, 12'h000, lat, nd, nf, npu, npo, wd);
    checks++; if (new_pc !== 16'h0402 || depth !== 5'd16) begin errors++; $display("[TB] FAIL first_ret: got pc=%h depth=%0d expected 0402 16", new_pc, depth); end
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 16'h0000, 12'h000, lat, nd, nf, npu, npo, wd);
    end
    checks++; if (depth !== 5'd0) begin errors++; $display("[TB] FAIL drain_depth: got %0d expected 0", depth); end
    issue(1'b1, 16'h0000, 12'h000, lat, nd, nf, npu, npo, wd);
    checks++; if (nf !== 0 || nd !== 1 || depth !== 5'd31) begin errors++; $display("[TB] FAIL underflow_wrap: got faults=%0d dones=%0d depth=%0d expected 0 1 31", nf, nd, depth); end
`endif
  endtask

  initial begin
    test_reset();
    test_call();
    test_nested();
    test_wrap_mask();
    test_busy_start();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
